zrle_codeword_gen: RTL and testbench

//  Zero-run-length codeword generator, directly upstream of the encoder shift streamer.

---
 rtl/zrle_codeword_gen.sv | 257 +++++++++++++++++++++++++
 tb/tb_zrle_codeword_gen.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zrle_codeword_gen.sv
`default_nettype none
// ============================================================================
// Module   : zrle_codeword_gen
// Purpose  : Zero-run-length codeword generator that sits in front of the
//            encoder shift streamer. Takes one DATA_W symbol per handshake.
//            Each zero run becomes a single codeword. Each nonzero symbol
//            becomes a HI codeword followed by a LO codeword. At end of
//            stream it raises flush_o and waits for the streamer to go idle.
// Ports    : clk_i, rst_ni  - clock, asynchronous active-low reset
//            data_i/last_i/vld_i/rdy_o - input symbol stream
//            data_o/shift_o/vld_o/rdy_i - codeword out (MSB-aligned, length)
//            flush_o/idle_i - streamer flush request / streamer idle status
//            idle_o         - generator idle with no pending output
// Config   : define ZRLE_CG_ASSERT_EN to compile in the run-time and
//            elaboration checks; datapath logic is the same either way.
// Revision : 1.0 - initial release
// ============================================================================
module zrle_codeword_gen #(
  parameter int DATA_W   = 8,
  parameter int MAX_ZRUN = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         last_i,
  input  logic                         vld_i,
  output logic                         rdy_o,
  output logic [2*DATA_W-1:0]          data_o,
  output logic [$clog2(DATA_W+1)-1:0]  shift_o,
  output logic                         vld_o,
  input  logic                         rdy_i,
  output logic                         flush_o,
  input  logic                         idle_i,
  output logic                         idle_o
);

  localparam int ZRUN_W  = $clog2(MAX_ZRUN);
  localparam int CNT_W   = ZRUN_W + 1;          // holds 0..MAX_ZRUN
  localparam int SHIFT_W = $clog2(DATA_W + 1);
  localparam int OUT_W   = 2 * DATA_W;

  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_ZRUN);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [SHIFT_W-1:0] LEN_RUN = SHIFT_W'(1 + ZRUN_W);
  localparam logic [SHIFT_W-1:0] LEN_HI  = SHIFT_W'(DATA_W);
  localparam logic [SHIFT_W-1:0] LEN_LO  = SHIFT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_EMIT_HI = 3'd2,
    S_EMIT_LO = 3'd3,
    S_DRAIN   = 3'd4,
    S_FLUSH   = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    run_cnt, run_cnt_nxt;
  logic                last_q, last_q_nxt;
  logic [DATA_W-1:0]   val_q, val_q_nxt;

  logic                slot_free;
  logic                xfer;
  logic                in_zero;
  logic                load;
  logic [OUT_W-1:0]    cw_data;
  logic [SHIFT_W-1:0]  cw_len;

  // Run codeword {0, n-1}; n==MAX_ZRUN wraps to all-ones in the count field.
  function automatic logic [OUT_W-1:0] run_word(input logic [CNT_W-1:0] n);
    logic [OUT_W-1:0] w;
    w = '0;
    w[OUT_W-2 -: ZRUN_W] = ZRUN_W'(n - CNT_ONE);
    return w;
  endfunction

  function automatic logic [OUT_W-1:0] hi_word(input logic [DATA_W-2:0] upper);
    logic [OUT_W-1:0] w;
    w = '0;
    w[OUT_W-1 -: DATA_W] = {1'b1, upper};
    return w;
  endfunction

  function automatic logic [OUT_W-1:0] lo_word(input logic lsb);
    logic [OUT_W-1:0] w;
    w = '0;
    w[OUT_W-1] = lsb;
    return w;
  endfunction

  assign slot_free = !vld_o || rdy_i;
  assign rdy_o     = slot_free && ((state == S_IDLE) || (state == S_RUN));
  assign xfer      = vld_i && rdy_o;
  assign in_zero   = (data_i == '0);
  // Gated by !vld_o so the last codeword reaches the streamer before flush.
  assign flush_o   = (state == S_FLUSH) && !vld_o;
  assign idle_o    = (state == S_IDLE) && !vld_o;

  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    last_q_nxt  = last_q;
    val_q_nxt   = val_q;
    load        = 1'b0;
    cw_data     = '0;
    cw_len      = '0;

    if (xfer && last_i) begin
      last_q_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (xfer) begin
          if (in_zero) begin
            run_cnt_nxt = CNT_ONE;
            state_nxt   = last_i ? S_DRAIN : S_RUN;
          end else begin
            load      = 1'b1;
            cw_data   = hi_word(data_i[DATA_W-1:1]);
            cw_len    = LEN_HI;
            val_q_nxt = data_i;
            state_nxt = S_EMIT_LO;
          end
        end
      end

      S_RUN: begin
        if (xfer) begin
          if (in_zero) begin
            if (run_cnt == CNT_MAX) begin
              // Full run goes out now; this zero starts the next run.
              load        = 1'b1;
              cw_data     = run_word(run_cnt);
              cw_len      = LEN_RUN;
              run_cnt_nxt = CNT_ONE;
            end else begin
              run_cnt_nxt = run_cnt + CNT_ONE;
            end
            if (last_i) begin
              state_nxt = S_DRAIN;
            end
          end else begin
            load        = 1'b1;
            cw_data     = run_word(run_cnt);
            cw_len      = LEN_RUN;
            val_q_nxt   = data_i;
            run_cnt_nxt = '0;
            state_nxt   = S_EMIT_HI;
          end
        end
      end

      S_EMIT_HI: begin
        if (slot_free) begin
          load      = 1'b1;
          cw_data   = hi_word(val_q[DATA_W-1:1]);
          cw_len    = LEN_HI;
          state_nxt = S_EMIT_LO;
        end
      end

      S_EMIT_LO: begin
        if (slot_free) begin
          load      = 1'b1;
          cw_data   = lo_word(val_q[0]);
          cw_len    = LEN_LO;
          state_nxt = last_q ? S_FLUSH : S_IDLE;
        end
      end

      S_DRAIN: begin
        if (slot_free) begin
          load      = 1'b1;
          cw_data   = run_word(run_cnt);
          cw_len    = LEN_RUN;
          state_nxt = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (!vld_o && idle_i) begin
          last_q_nxt  = 1'b0;
          run_cnt_nxt = '0;
          state_nxt   = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      run_cnt <= '0;
      last_q  <= 1'b0;
      val_q   <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_cnt_nxt;
      last_q  <= last_q_nxt;
      val_q   <= val_q_nxt;
    end
  end

  // Single-entry output register; load is only raised when slot_free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_o   <= 1'b0;
      data_o  <= '0;
      shift_o <= '0;
    end else if (load) begin
      vld_o   <= 1'b1;
      data_o  <= cw_data;
      shift_o <= cw_len;
    end else if (rdy_i) begin
      vld_o   <= 1'b0;
    end
  end

`ifdef ZRLE_CG_ASSERT_EN
  if ((1 + ZRUN_W > DATA_W) || (MAX_ZRUN != (1 << ZRUN_W))) begin : g_param_chk
    $error("zrle_codeword_gen: illegal DATA_W=%0d / MAX_ZRUN=%0d", DATA_W, MAX_ZRUN);
  end

  logic [OUT_W-1:0] low_mask;
  assign low_mask = {OUT_W{1'b1}} >> shift_o;

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (vld_o) begin
        assert ((shift_o >= LEN_LO) && (shift_o <= LEN_HI))
          else $display("%0t zrle_codeword_gen: shift_o %0d out of range", $time, shift_o);
        assert ((data_o & low_mask) == '0)
          else $display("%0t zrle_codeword_gen: data_o bits below codeword set", $time);
      end
      assert (run_cnt <= CNT_MAX)
        else $display("%0t zrle_codeword_gen: run_cnt %0d exceeds max", $time, run_cnt);
    end
  end

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (vld_o && !rdy_i) |=> ($stable(data_o) && $stable(shift_o)))
    else $display("%0t zrle_codeword_gen: output changed under stall", $time);

  a_flush_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(flush_o && vld_o))
    else $display("%0t zrle_codeword_gen: flush_o with vld_o", $time);
`else
  // Checks not compiled in.
`endif

endmodule
`default_nettype wire

// File: tb/tb_zrle_codeword_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_zrle_codeword_gen
// Purpose  : Self-checking bench for zrle_codeword_gen (DATA_W=8,
//            MAX_ZRUN=16). A table of symbol streams is run through the DUT;
//            a reference encoder queues the expected codewords, and a monitor
//            pops and compares them on every output handshake. Hand-written
//            sequences cover output stalls and reset mid-codeword.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zrle_codeword_gen;

  localparam int DATA_W   = 8;
  localparam int MAX_ZRUN = 16;
  localparam int LIMIT    = 300;

  logic        clk_i;
  logic        rst_ni;
  logic [7:0]  data_i;
  logic        last_i;
  logic        vld_i;
  logic        rdy_o;
  logic [15:0] data_o;
  logic [3:0]  shift_o;
  logic        vld_o;
  logic        rdy_i;
  logic        flush_o;
  logic        idle_i;
  logic        idle_o;

  zrle_codeword_gen #(.DATA_W(DATA_W), .MAX_ZRUN(MAX_ZRUN)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (data_i),
    .last_i  (last_i),
    .vld_i   (vld_i),
    .rdy_o   (rdy_o),
    .data_o  (data_o),
    .shift_o (shift_o),
    .vld_o   (vld_o),
    .rdy_i   (rdy_i),
    .flush_o (flush_o),
    .idle_i  (idle_i),
    .idle_o  (idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  l;
  } cw_t;

  // Stream = nlead zeros, then nsym symbols (symbol k in syms[8k+:8]);
  // last_i rides on the final symbol. ncw/fd/fl are the hand-derived
  // codeword count and first codeword.
  typedef struct {
    int          nlead;
    int          nsym;
    logic [63:0] syms;
    int          ncw;
    logic [15:0] fd;
    logic [3:0]  fl;
  } vec_t;

  vec_t        tbl[11];
  cw_t         exp_q[$];
  cw_t         rx_log[$];
  logic [7:0]  stim_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          viol     = 0;
  bit          bp_en    = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void push_run(input int n);
    cw_t c;
    logic [3:0] m;
    m = 4'(n - 1);
    c.d = {1'b0, m, 11'h000};
    c.l = 4'd5;
    exp_q.push_back(c);
  endfunction

  // Reference zero-run-length encoder over stim_q.
  function automatic void build_exp();
    int run;
    logic [7:0] v;
    cw_t c;
    run = 0;
    foreach (stim_q[i]) begin
      v = stim_q[i];
      if (v == 8'h00) begin
        if (run == MAX_ZRUN) begin
          push_run(run);
          run = 0;
        end
        run++;
      end else begin
        if (run > 0) push_run(run);
        run = 0;
        c.d = {1'b1, v[7:1], 8'h00}; c.l = 4'd8; exp_q.push_back(c);
        c.d = {v[0], 15'h0000};      c.l = 4'd1; exp_q.push_back(c);
      end
    end
    if (run > 0) push_run(run);
  endfunction

  // Random output backpressure, applied off the sampling edge.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (bp_en) rdy_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard: sample on the falling edge.
  initial begin
    logic        stall_q;
    logic [15:0] hold_d;
    logic [3:0]  hold_l;
    cw_t         e;
    cw_t         r;
    stall_q = 1'b0;
    hold_d  = '0;
    hold_l  = '0;
    forever begin
      @(negedge clk_i or negedge rst_ni);
      if (!rst_ni || clk_i) begin
        stall_q = 1'b0;
        continue;
      end
      if (vld_o && flush_o) viol++;
      if (stall_q && (!vld_o || data_o !== hold_d || shift_o !== hold_l)) viol++;
      stall_q = vld_o && !rdy_i;
      hold_d  = data_o;
      hold_l  = shift_o;
      if (vld_o && rdy_i) begin
        r.d = data_o;
        r.l = shift_o;
        rx_log.push_back(r);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_codeword", {12'h0, shift_o, data_o}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {16'h0, data_o}, {16'h0, e.d});
          check("sb_len", {28'h0, shift_o}, {28'h0, e.l});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the symbol is taken.
  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    data_i = d;
    last_i = l;
    vld_i  = 1'b1;
    @(negedge clk_i);
    while (!rdy_o && t < LIMIT) begin
      t++;
      @(negedge clk_i);
    end
    if (!rdy_o) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    vld_i  = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic run_stream(input vec_t v, input string tag);
    int t;
    int base;
    int vbase;
    bit hold_ok;
    stim_q.delete();
    for (int i = 0; i < v.nlead; i++) stim_q.push_back(8'h00);
    for (int k = 0; k < v.nsym; k++) stim_q.push_back(v.syms[8*k +: 8]);
    build_exp();
    base  = rx_log.size();
    vbase = viol;
    for (int i = 0; i < stim_q.size(); i++) send(stim_q[i], (i == stim_q.size() - 1));

    t = 0;
    @(negedge clk_i);
    while (!flush_o && t < LIMIT) begin
      t++;
      @(negedge clk_i);
    end
    check({tag, "_flush_seen"}, {31'h0, flush_o}, 32'd1);
    check({tag, "_rdy_in_flush"}, {31'h0, rdy_o}, 32'd0);
    hold_ok = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      if (!flush_o || idle_o) hold_ok = 1'b0;
    end
    check({tag, "_flush_hold"}, {31'h0, hold_ok}, 32'd1);
    bp_en = 1'b0;
    @(posedge clk_i);
    #1;
    rdy_i  = 1'b1;
    idle_i = 1'b1;
    t = 0;
    @(negedge clk_i);
    while (!idle_o && t < LIMIT) begin
      t++;
      @(negedge clk_i);
    end
    check({tag, "_idle_o"}, {31'h0, idle_o}, 32'd1);
    check({tag, "_flush_off"}, {31'h0, flush_o}, 32'd0);
    @(posedge clk_i);
    #1;
    idle_i = 1'b0;
    check({tag, "_ncw"}, rx_log.size() - base, v.ncw);
    if (rx_log.size() > base) begin
      check({tag, "_first_cw"}, {12'h0, rx_log[base].l, rx_log[base].d}, {12'h0, v.fl, v.fd});
    end else begin
      check({tag, "_first_cw_missing"}, 32'd0, 32'd1);
    end
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_protocol"}, viol - vbase, 0);
  endtask

  // Stall the run codeword and then the HI codeword; inputs offered
  // while rdy_o=0 (including a zero with last) must be ignored.
  task automatic t3_stall();
    int t;
    int base;
    stim_q.delete();
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h07);
    build_exp();
    base = rx_log.size();
    send(8'h00, 1'b0);
    send(8'h07, 1'b0);
    rdy_i  = 1'b0;
    vld_i  = 1'b1;
    data_i = 8'h00;
    last_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("t3_rdy_o_run", {31'h0, rdy_o}, 32'd0);
      check("t3_run_hold", {11'h0, vld_o, shift_o, data_o}, {11'h0, 1'b1, 4'd5, 16'h0000});
    end
    @(posedge clk_i);
    #1;
    rdy_i = 1'b1;
    @(posedge clk_i);
    #1;
    rdy_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("t3_rdy_o_hi", {31'h0, rdy_o}, 32'd0);
      check("t3_hi_hold", {11'h0, vld_o, shift_o, data_o}, {11'h0, 1'b1, 4'd8, 16'h8300});
    end
    @(posedge clk_i);
    #1;
    vld_i  = 1'b0;
    last_i = 1'b0;
    rdy_i  = 1'b1;
    t = 0;
    @(negedge clk_i);
    while (!idle_o && t < LIMIT) begin
      t++;
      @(negedge clk_i);
    end
    check("t3_idle_o", {31'h0, idle_o}, 32'd1);
    check("t3_no_flush", {31'h0, flush_o}, 32'd0);
    check("t3_ncw", rx_log.size() - base, 3);
    check("t3_exp_left", exp_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  // Reset while the HI codeword sits stalled in the output register.
  task automatic t6_reset();
    rdy_i = 1'b0;
    send(8'h05, 1'b1);
    @(negedge clk_i);
    check("t6_pre_vld", {31'h0, vld_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_vld", {31'h0, vld_o}, 32'd0);
    check("t6_rst_flush", {31'h0, flush_o}, 32'd0);
    check("t6_rst_idle", {31'h0, idle_o}, 32'd1);
    check("t6_rst_out", {12'h0, shift_o, data_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rdy_i  = 1'b1;
    @(posedge clk_i);
    #1;
    run_stream(tbl[0], "t6_t1");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    vld_i  = 1'b0;
    data_i = 8'h00;
    last_i = 1'b0;
    rdy_i  = 1'b1;
    idle_i = 1'b0;

    //              nlead nsym syms                     ncw first   len
    tbl[0]  = '{3,  1, 64'h05,             3, 16'h1000, 4'd5};  // T1
    tbl[1]  = '{18, 0, 64'h0,              2, 16'h7800, 4'd5};  // T2
    tbl[2]  = '{0,  1, 64'hFF,             2, 16'hFF00, 4'd8};  // T4
    tbl[3]  = '{1,  0, 64'h0,              1, 16'h0000, 4'd5};  // T5
    tbl[4]  = '{16, 1, 64'h80,             3, 16'h7800, 4'd5};
    tbl[5]  = '{17, 1, 64'h01,             4, 16'h7800, 4'd5};
    tbl[6]  = '{0,  4, 64'hA5_00_00_3C,    5, 16'h9E00, 4'd8};
    tbl[7]  = '{32, 0, 64'h0,              2, 16'h7800, 4'd5};
    tbl[8]  = '{33, 0, 64'h0,              3, 16'h7800, 4'd5};
    tbl[9]  = '{0,  3, 64'h00_02_01,       5, 16'h8000, 4'd8};
    tbl[10] = '{5,  0, 64'h0,              1, 16'h2000, 4'd5};

    #3;
    check("rst_vld_o", {31'h0, vld_o}, 32'd0);
    check("rst_flush_o", {31'h0, flush_o}, 32'd0);
    check("rst_data_o", {16'h0, data_o}, 32'h0);
    check("rst_shift_o", {28'h0, shift_o}, 32'h0);
    check("rst_idle_o", {31'h0, idle_o}, 32'd1);
    check("rst_rdy_o", {31'h0, rdy_o}, 32'd1);

    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 11; i++) begin
      bp_en = (i % 2) == 1;
      run_stream(tbl[i], $sformatf("vec%0d", i));
      bp_en = 1'b0;
      rdy_i = 1'b1;
    end

    t3_stall();
    t6_reset();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
